// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter family.
package counter_pkg;

    localparam int CNT_MAX_W     = 16;
    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // Per-cycle operation after the clear path has been resolved.
    typedef enum logic [1:0] {
        OP_LD,
        OP_BOTH,
        OP_UP,
        OP_DN
    } cnt_op_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
interface mod_updown_counter_if #(
    parameter int WIDTH = 5
);
    logic             cntup;
    logic             cntdn;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] res;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output cntup, cntdn, ld, ld_val,
        input  res, tc, wrap, ovf
    );

    modport slave (
        input  cntup, cntdn, ld, ld_val,
        output res, tc, wrap, ovf
    );
endinterface

// File: rtl/mod_updown_counter_cnt_next_logic.sv
// Combinational step logic: next count value, limit detects and terminal count.
module cnt_next_logic
    import counter_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32,
    parameter int SAT     = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] res,
    input  logic             clr,
    input  logic             ld,
    input  logic             cntup,
    input  logic             cntdn,
    output logic [WIDTH-1:0] next_res,
    output logic             hit_max,
    output logic             hit_min,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic up_only;
    logic dn_only;

    assign up_only = cntup & ~cntdn;
    assign dn_only = cntdn & ~cntup;
    assign hit_max = (res == MAX_VAL);
    assign hit_min = (res == '0);

    assign tc = ~clr & ~ld & ((up_only & hit_max) | (dn_only & hit_min));

    always_comb begin
        // NOTE: default assigned first so every path drives next_res and no latch is inferred.
        next_res = res;
        if (up_only) begin
            // The limit compare is explicit even for full binary range, so +1 never carries out.
            if (hit_max) next_res = (SAT == CNT_MODE_SAT) ? MAX_VAL : '0;
            else         next_res = res + WIDTH'(1);
        end else if (dn_only) begin
            if (hit_min) next_res = (SAT == CNT_MODE_SAT) ? '0 : MAX_VAL;
            else         next_res = res - WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised modulo up/down counter with load, wrap/saturate mode,
// terminal count, one-cycle limit pulse and sticky overflow.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32,
    parameter int SAT     = CNT_MODE_WRAP
) (
    input  logic                 clk,
    input  logic                 clr,
    mod_updown_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || WIDTH > CNT_MAX_W || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
        clog2(MODULUS) > WIDTH || (SAT != CNT_MODE_WRAP && SAT != CNT_MODE_SAT)) begin : g_bad_param
        $fatal(1, "mod_updown_counter: illegal WIDTH/MODULUS/SAT combination");
    end

    logic [WIDTH-1:0] res_q;
    logic             wrap_q;
    logic             ovf_q;
    logic [WIDTH-1:0] res_d;
    logic             wrap_d;
    logic             ovf_d;
    logic [WIDTH-1:0] next_res;
    logic [WIDTH-1:0] ld_clamped;
    logic             hit_max;
    logic             hit_min;
    logic             tc;
    cnt_op_e          op;

    cnt_next_logic #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .SAT     (SAT)
    ) u_next (
        .res      (res_q),
        .clr      (clr),
        .ld       (bus.ld),
        .cntup    (bus.cntup),
        .cntdn    (bus.cntdn),
        .next_res (next_res),
        .hit_max  (hit_max),
        .hit_min  (hit_min),
        .tc       (tc)
    );

    assign ld_clamped = (32'(bus.ld_val) >= 32'(MODULUS)) ? MAX_VAL : bus.ld_val;

    always_comb begin
        op = OP_BOTH;
        if (bus.ld)                      op = OP_LD;
        else if (bus.cntup && bus.cntdn) op = OP_BOTH;
        else if (bus.cntup)              op = OP_UP;
        else if (bus.cntdn)              op = OP_DN;
    end

    // Both-requests and idle share the default: hold count, drop pulse, keep ovf.
    always_comb begin
        res_d  = res_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        case (op)
            OP_LD: begin
                res_d = ld_clamped;
                ovf_d = 1'b0;
            end
            OP_UP: begin
                res_d  = next_res;
                wrap_d = hit_max;
                ovf_d  = ovf_q | hit_max;
            end
            OP_DN: begin
                res_d  = next_res;
                wrap_d = hit_min;
                ovf_d  = ovf_q | hit_min;
            end
            default: ;
        endcase
    end

    // Clear sits outside the datapath mux so unknown controls during clear cannot reach res.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (clr) begin
            res_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            res_q  <= res_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.res  = res_q;
    assign bus.wrap = wrap_q;
    assign bus.ovf  = ovf_q;
    assign bus.tc   = tc;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Three counter variants (wrap M=10, saturate M=10, full-range wrap M=32) driven
// with shared stimulus and compared every cycle against an arithmetic model.
module tb_mod_updown_counter;

    localparam int N = 3;

    typedef struct packed {
        int res;
        bit wrap;
        bit ovf;
    } mstate_t;

    logic       clk = 1'b0;
    logic       s_clr, s_up, s_dn, s_ld;
    logic [4:0] s_val;
    bit         chk_en = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    int         mod_a[N] = '{10, 10, 32};
    bit         sat_a[N] = '{1'b0, 1'b1, 1'b0};
    mstate_t    m[N];

    always #5 clk = ~clk;

    mod_updown_counter_if #(.WIDTH(5)) if_w ();
    mod_updown_counter_if #(.WIDTH(5)) if_s ();
    mod_updown_counter_if #(.WIDTH(5)) if_f ();

    assign if_w.cntup = s_up;  assign if_w.cntdn = s_dn;  assign if_w.ld = s_ld;  assign if_w.ld_val = s_val;
    assign if_s.cntup = s_up;  assign if_s.cntdn = s_dn;  assign if_s.ld = s_ld;  assign if_s.ld_val = s_val;
    assign if_f.cntup = s_up;  assign if_f.cntdn = s_dn;  assign if_f.ld = s_ld;  assign if_f.ld_val = s_val;

    mod_updown_counter #(.WIDTH(5), .MODULUS(10), .SAT(0)) dut_w (.clk(clk), .clr(s_clr), .bus(if_w.slave));
    mod_updown_counter #(.WIDTH(5), .MODULUS(10), .SAT(1)) dut_s (.clk(clk), .clr(s_clr), .bus(if_s.slave));
    mod_updown_counter #(.WIDTH(5), .MODULUS(32), .SAT(0)) dut_f (.clk(clk), .clr(s_clr), .bus(if_f.slave));

    logic [4:0] d_res[N];
    logic       d_wrap[N], d_ovf[N], d_tc[N];
    assign d_res[0] = if_w.res;  assign d_wrap[0] = if_w.wrap;  assign d_ovf[0] = if_w.ovf;  assign d_tc[0] = if_w.tc;
    assign d_res[1] = if_s.res;  assign d_wrap[1] = if_s.wrap;  assign d_ovf[1] = if_s.ovf;  assign d_tc[1] = if_s.tc;
    assign d_res[2] = if_f.res;  assign d_wrap[2] = if_f.wrap;  assign d_ovf[2] = if_f.ovf;  assign d_tc[2] = if_f.tc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Counter behaviour stated as plain integer arithmetic.
    function automatic mstate_t model_step(input mstate_t cur, input int modulus, input bit sat,
                                           input bit clr, input bit ld, input int val,
                                           input bit up, input bit dn);
        mstate_t nx;
        int      n;
        nx      = cur;
        nx.wrap = 1'b0;
        if (clr) begin
            nx.res = 0; nx.ovf = 1'b0;
        end else if (ld) begin
            nx.res = (val >= modulus) ? modulus - 1 : val;
            nx.ovf = 1'b0;
        end else if (up && !dn) begin
            n = cur.res + 1;
            if (n >= modulus) begin
                nx.res = sat ? modulus - 1 : n % modulus;
                nx.wrap = 1'b1; nx.ovf = 1'b1;
            end else nx.res = n;
        end else if (dn && !up) begin
            n = cur.res - 1;
            if (n < 0) begin
                nx.res = sat ? 0 : n + modulus;
                nx.wrap = 1'b1; nx.ovf = 1'b1;
            end else nx.res = n;
        end
        return nx;
    endfunction

    function automatic bit model_tc(input int res, input int modulus, input bit clr, input bit ld,
                                    input bit up, input bit dn);
        if (clr || ld || (up == dn)) return 1'b0;
        return up ? (res == modulus - 1) : (res == 0);
    endfunction

    initial for (int k = 0; k < N; k++) m[k] = '0;

    always @(posedge clk) begin
        for (int k = 0; k < N; k++)
            m[k] <= model_step(m[k], mod_a[k], sat_a[k], s_clr, s_ld, int'(s_val), s_up, s_dn);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("res[%0d]", k),  32'(d_res[k]),  32'(m[k].res));
                check($sformatf("wrap[%0d]", k), 32'(d_wrap[k]), 32'(m[k].wrap));
                check($sformatf("ovf[%0d]", k),  32'(d_ovf[k]),  32'(m[k].ovf));
                check($sformatf("tc[%0d]", k),   32'(d_tc[k]),
                      32'(model_tc(m[k].res, mod_a[k], s_clr, s_ld, s_up, s_dn)));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq[12];
        seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        s_clr = 1'b1; s_up = 1'b0; s_dn = 1'b0; s_ld = 1'b0; s_val = '0;
        #1;

        // 1: clear for two cycles with random controls
        for (int i = 0; i < 2; i++) begin
            s_up = 1'($urandom); s_dn = 1'($urandom); s_ld = 1'($urandom); s_val = 5'($urandom);
            #1;
            check("t1_tc_during_clr", 32'(if_w.tc), 32'd0);
            tick();
            chk_en = 1'b1;
        end
        check("t1_res", 32'(if_w.res), 32'd0);
        check("t1_wrap", 32'(if_w.wrap), 32'd0);
        check("t1_ovf", 32'(if_w.ovf), 32'd0);
        check("t1_res_sat", 32'(if_s.res), 32'd0);

        // 2: wrap mode count-up through the limit
        s_clr = 1'b0; s_ld = 1'b0; s_dn = 1'b0; s_up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("t2_tc_%0d", i), 32'(if_w.tc), 32'(i == 9));
            tick();
            check($sformatf("t2_res_%0d", i), 32'(if_w.res), 32'(seq[i]));
            check($sformatf("t2_wrap_%0d", i), 32'(if_w.wrap), 32'(i == 9));
            check($sformatf("t2_ovf_%0d", i), 32'(if_w.ovf), 32'(i >= 9));
        end
        check("t2_full_res", 32'(if_f.res), 32'd12);

        // 3: saturate mode from 8
        s_up = 1'b0; s_ld = 1'b1; s_val = 5'd8;
        tick();
        check("t3_ld_res", 32'(if_s.res), 32'd8);
        check("t3_ld_ovf", 32'(if_s.ovf), 32'd0);
        s_ld = 1'b0; s_up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_res_%0d", i), 32'(if_s.res), 32'd9);
            check($sformatf("t3_wrap_%0d", i), 32'(if_s.wrap), 32'(i != 0));
        end
        check("t3_ovf", 32'(if_s.ovf), 32'd1);

        // 4: down-wrap from 0, then simultaneous requests hold
        s_up = 1'b0; s_clr = 1'b1;
        tick();
        s_clr = 1'b0; s_dn = 1'b1;
        #1;
        check("t4_tc_dn", 32'(if_w.tc), 32'd1);
        tick();
        check("t4_res", 32'(if_w.res), 32'd9);
        check("t4_wrap", 32'(if_w.wrap), 32'd1);
        check("t4_sat_res", 32'(if_s.res), 32'd0);
        check("t4_sat_wrap", 32'(if_s.wrap), 32'd1);
        s_up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t4_both_tc_%0d", i), 32'(if_w.tc), 32'd0);
            tick();
            check($sformatf("t4_both_res_%0d", i), 32'(if_w.res), 32'd9);
            check($sformatf("t4_both_wrap_%0d", i), 32'(if_w.wrap), 32'd0);
            check($sformatf("t4_both_ovf_%0d", i), 32'(if_w.ovf), 32'd1);
        end

        // 5: load clamps and has priority over counting
        s_up = 1'b0; s_dn = 1'b0; s_ld = 1'b1; s_val = 5'd21;
        tick();
        check("t5_clamp_res", 32'(if_w.res), 32'd9);
        check("t5_clamp_ovf", 32'(if_w.ovf), 32'd0);
        check("t5_full_ld", 32'(if_f.res), 32'd21);
        s_up = 1'b1; s_val = 5'd3;
        #1;
        check("t5_tc_ld", 32'(if_w.tc), 32'd0);
        tick();
        check("t5_ld_up_res", 32'(if_w.res), 32'd3);

        // 6: clear aborts a count in progress
        s_up = 1'b0; s_val = 5'd5;
        tick();
        s_ld = 1'b0; s_up = 1'b1;
        tick();
        check("t6_res6", 32'(if_w.res), 32'd6);
        s_clr = 1'b1;
        tick();
        check("t6_clr_res", 32'(if_w.res), 32'd0);
        s_clr = 1'b0;
        tick();
        check("t6_after_res", 32'(if_w.res), 32'd1);

        // Full binary range roll-over still flags wrap/ovf
        s_up = 1'b0; s_ld = 1'b1; s_val = 5'd31;
        tick();
        s_ld = 1'b0; s_up = 1'b1;
        #1;
        check("full_tc", 32'(if_f.tc), 32'd1);
        tick();
        check("full_res", 32'(if_f.res), 32'd0);
        check("full_wrap", 32'(if_f.wrap), 32'd1);
        check("full_ovf", 32'(if_f.ovf), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            s_clr = ($urandom_range(0, 31) == 0);
            s_ld  = ($urandom_range(0, 7) == 0);
            s_up  = 1'($urandom);
            s_dn  = 1'($urandom);
            s_val = 5'($urandom);
            tick();
        end

        s_clr = 1'b0; s_ld = 1'b0; s_up = 1'b0; s_dn = 1'b0;
        tick();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
